// File: rtl/alu_mdu_pkg.sv
// Shared execution-unit constants: ALU op codes, MDU op codes and MDU FSM states.
package alu_mdu_pkg;
  localparam int ALU_OP_LEN = 4;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_AND = 4'd2;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_OR  = 4'd3;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_XOR = 4'd4;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_SLL = 4'd5;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_SRL = 4'd6;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_SRA = 4'd7;

  localparam int MDU_OP_LEN  = 2;
  localparam int MDU_NUM_OPS = 4;
  localparam logic [MDU_OP_LEN-1:0] MDU_OP_MUL  = 2'd0;
  localparam logic [MDU_OP_LEN-1:0] MDU_OP_MULU = 2'd1;
  localparam logic [MDU_OP_LEN-1:0] MDU_OP_DIV  = 2'd2;
  localparam logic [MDU_OP_LEN-1:0] MDU_OP_DIVU = 2'd3;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;
endpackage

// File: rtl/alu_mdu_step.sv
// One iteration of the iterative multiplier/divider: shift-add or restoring shift-subtract.
module alu_mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum, rem_sh, diff;

  // acc holds {hi, lo}: product-so-far/multiplier for MUL, remainder/quotient for DIV
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a : '0)};
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, a};
    if (is_div)
      acc_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit: operands reduced to magnitudes, WIDTH-step core, sign fixup.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OP_LEN = MDU_OP_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_LEN-1:0] op,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              div_zero,
  output logic              busy
);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

  mdu_state_t         state;
  logic [WIDTH-1:0]   cnt, a_q;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [1:0]         op_q;
  logic               neg_lo, neg_hi, dz_q;

  logic [31:0]        op_ext;
  logic               op_ok, accept, is_signed, is_div, s1, s2, dz_in;
  logic [WIDTH-1:0]   m1, m2;

  always_comb begin
    op_ext    = 32'(op);
    op_ok     = op_ext < 32'(MDU_NUM_OPS);
    in_ready  = (state == MDU_IDLE) && !(in_valid && !op_ok);
    accept    = in_valid && in_ready;
    busy      = (state != MDU_IDLE);
    is_signed = !op[0];
    is_div    = op[1];
    s1        = is_signed && in1[WIDTH-1];
    s2        = is_signed && in2[WIDTH-1];
    m1        = s1 ? -in1 : in1;
    m2        = s2 ? -in2 : in2;
    dz_in     = is_div && (in2 == '0);
  end

  alu_mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_q[1]),
    .a       (a_q),
    .acc     (acc),
    .acc_nxt (acc_nxt)
  );

  // Outputs load one edge after DONE is entered, so hi/lo stay zero until out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MDU_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      acc       <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      dz_q      <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
    end else if (flush) begin
      state     <= MDU_IDLE;
      cnt       <= '0;
      dz_q      <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: if (accept) begin
          op_q   <= op[1:0];
          cnt    <= '0;
          neg_lo <= s1 ^ s2;
          neg_hi <= is_div ? s1 : (s1 ^ s2);
          if (dz_in) begin
            acc   <= {in1, {WIDTH{1'b1}}};
            dz_q  <= 1'b1;
            state <= MDU_DONE;
          end else begin
            a_q   <= is_div ? m2 : m1;
            acc   <= {{WIDTH{1'b0}}, (is_div ? m1 : m2)};
            dz_q  <= 1'b0;
            state <= MDU_CALC;
          end
        end
        MDU_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= MDU_FIX;
          end
        end
        MDU_FIX: begin
          if (op_q[1])
            acc <= {(neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]),
                    (neg_lo ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0])};
          else
            acc <= neg_lo ? -acc : acc;
          state <= MDU_DONE;
        end
        MDU_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            hi        <= acc[2*WIDTH-1:WIDTH];
            lo        <= acc[WIDTH-1:0];
            div_zero  <= dz_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
            state     <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed + random bench for alu_mdu with a reference-model scoreboard.
module tb_alu_mdu;
  import alu_mdu_pkg::*;
  localparam int W = 32;

  logic                  clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [MDU_OP_LEN-1:0] op = '0;
  logic [W-1:0]          in1 = '0, in2 = '0;
  logic                  in_ready, out_valid, div_zero, busy;
  logic [W-1:0]          hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0;

  alu_mdu #(.WIDTH(W), .OP_LEN(MDU_OP_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .hi(hi), .lo(lo), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    e.dz = 1'b0; e.lat = W + 2; e.hi = '0; e.lo = '0;
    case (o)
      MDU_OP_MUL:  begin p = longint'($signed(a)) * longint'($signed(b)); e.hi = p[63:32]; e.lo = p[31:0]; end
      MDU_OP_MULU: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1; e.lat = 1;
        end else if (o == MDU_OP_DIVU) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = a; e.hi = '0;
        end else begin
          e.lo = $signed(a) / $signed(b); e.hi = $signed(a) % $signed(b);
        end
      end
    endcase
    return e;
  endfunction

  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int lat;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 1);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    sb.push_back(model(o, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("hi", hi, e.hi);
    chk("lo", lo, e.lo);
    chk("div_zero", 32'(div_zero), 32'(e.dz));
    chk("ready_vs_valid", 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_hi", hi, e.hi);
      chk("hold_lo", lo, e.lo);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ret_idle", 32'(in_ready), 1);
    chk("valid_drop", 32'(out_valid), 0);
    chk("lo_zero", lo, 0);
  endtask

  task automatic no_result(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk(tag, 32'(seen), 0);
  endtask

  task automatic abort(input bit use_rst);
    @(negedge clk);
    in_valid = 1'b1; op = MDU_OP_MULU; in1 = 32'd123; in2 = 32'd456;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    if (use_rst) begin
      rst_n = 1'b0; #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      no_result("rst_no_result");
    end else begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 0);
      chk("flush_ready", 32'(in_ready), 1);
      no_result("flush_no_result");
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_dz", 32'(div_zero), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset_ready", 32'(in_ready), 1);

    run(MDU_OP_MULU, 32'd7, 32'd6, 0);
    run(MDU_OP_MUL, -32'sd3, 32'd5, 0);
    run(MDU_OP_DIV, -32'sd7, 32'd2, 0);
    run(MDU_OP_DIVU, 32'd100, 32'd7, 10);
    run(MDU_OP_DIVU, 32'd5, 32'd0, 0);
    run(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(MDU_OP_DIV, -32'sd9, 32'd0, 2);
    run(MDU_OP_MUL, 32'h8000_0000, 32'h8000_0000, 0);
    run(MDU_OP_DIV, 32'd7, -32'sd2, 0);
    run(MDU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run(MDU_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    abort(1'b1);
    run(MDU_OP_MULU, 32'd2, 32'd3, 0);
    abort(1'b0);
    run(MDU_OP_MULU, 32'd2, 32'd3, 0);

    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = MDU_OP_MULU; in1 = 32'd9; in2 = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_busy", 32'(busy), 0);
    no_result("flush_accept_no_result");

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run(ro, ra, rb, i % 3);
    end

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
